// File: rtl/freq_meas_pkg.sv
// Shared types and defaults for the frequency measurement controller.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int unsigned DEF_GATE_CYCLES = 32'd1000000;
  localparam int          DEF_CNT_W       = 32;

endpackage

// File: rtl/freq_meas_ctrl_sig_edge_counter.sv
// Synchronizes sig_in, detects rising edges and counts them with saturation.
// count/sat present the value including the current cycle's edge, so a
// consumer latching them on the final enabled cycle sees every edge.
module sig_edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the delayed copy
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             rise;

  assign rise  = sync_q[1] & ~sync_q[2];
  assign count = cnt_d;
  assign sat   = sat_d;

  // Shift the asynchronous input through the synchronizer and delay flop
  always_comb begin
    sync_d = {sync_q[1:0], sig_in};
  end

  // Saturating edge counter; an edge at full scale only raises sat
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (enable && rise) begin
      if (&cnt_q) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clocks
// and hands the result over a valid/ready handshake.
// Optional macro FREQ_MEAS_CONTINUOUS_EN: accepting a result re-arms the next
// measurement immediately, and abort is also honoured in HOLD.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int          CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sig_in,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_count,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [CNT_W-1:0] result_count_q, result_count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] edge_count;
  logic             edge_sat;
  logic             gate_last;

  assign gate_last    = (timer_q == GATE_CYCLES - 32'd1);
  assign busy         = (state_q == ARM) || (state_q == GATE);
  assign result_valid = (state_q == HOLD);
  assign result_count = result_count_q;
  assign overflow     = overflow_q;

  sig_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clock  (clock),
    .reset  (reset),
    .sig_in (sig_in),
    .clear  (state_q == ARM),
    .enable (state_q == GATE),
    .count  (edge_count),
    .sat    (edge_sat)
  );

  // Measurement sequencing: IDLE -> ARM (1 cycle) -> GATE -> HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM:  state_d = abort ? IDLE : GATE;
      GATE: begin
        if (abort)          state_d = IDLE;
        else if (gate_last) state_d = HOLD;
      end
      HOLD: begin
`ifdef FREQ_MEAS_CONTINUOUS_EN
        if (abort)             state_d = IDLE;
        else if (result_ready) state_d = ARM;
`else
        if (result_ready)      state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate timer and result capture; abort on the last gate cycle skips capture
  always_comb begin
    timer_d        = timer_q;
    result_count_d = result_count_q;
    overflow_d     = overflow_q;
    if (state_q == ARM) begin
      timer_d    = '0;
      overflow_d = 1'b0;
    end
    if (state_q == GATE) begin
      timer_d = timer_q + 32'd1;
      if (gate_last && !abort) begin
        result_count_d = edge_count;
        overflow_d     = edge_sat;
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      result_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      result_count_q <= result_count_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: a CNT_W=32 instance (a) and a CNT_W=4 instance (b)
// share control inputs; b always sees a period-2 signal and saturates.
module tb_freq_meas_ctrl;

  localparam int unsigned G = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        result_ready = 1'b0;
  logic        sig_a = 1'b0;
  logic        sig_b = 1'b0;
  logic        busy_a, valid_a, ovf_a;
  logic [31:0] cnt_a;
  logic        busy_b, valid_b, ovf_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int h_a = 0;
  int h_b = 1;

  typedef struct {
    logic [31:0] cnt;
    logic        ovf;
  } res_t;
  res_t qa[$];
  res_t qb[$];

  typedef struct {
    int          half;
    logic [31:0] exp_cnt;
  } vec_t;
  vec_t vecs[6];

  always #5 clock = ~clock;

  freq_meas_ctrl #(.GATE_CYCLES(G), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .sig_in(sig_a), .result_ready(result_ready), .busy(busy_a),
    .result_valid(valid_a), .result_count(cnt_a), .overflow(ovf_a)
  );

  freq_meas_ctrl #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .sig_in(sig_b), .result_ready(result_ready), .busy(busy_b),
    .result_valid(valid_b), .result_count(cnt_b), .overflow(ovf_b)
  );

  // half-period h toggling square wave as a function of cycle number; h=0 is constant 1
  function automatic logic gen(input int h, input int c);
    if (h == 0) return 1'b1;
    return ((c / h) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    sig_a = gen(h_a, cyc);
    sig_b = gen(h_b, cyc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_result(input logic [31:0] c);
    qa.push_back('{c, 1'b0});
    qb.push_back('{32'd15, 1'b1});
  endtask

  // Step until result_valid (bounded), check latency, then score both instances
  task automatic wait_result(input int exp_lat, input string tag);
    int   n;
    res_t ea, eb;
    n = 0;
    while (!valid_a && n < 400) begin
      tick();
      n++;
      if (n == 1) start = 1'b0;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (qa.size() == 0 || qb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard: got empty queue expected pending result", tag);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      if (valid_a) begin
        check({tag, "_count_a"}, cnt_a, ea.cnt);
        check_bit({tag, "_ovf_a"}, ovf_a, ea.ovf);
        check_bit({tag, "_busy_a"}, busy_a, 1'b0);
        check_bit({tag, "_valid_b"}, valid_b, 1'b1);
        check({tag, "_count_b"}, 32'(cnt_b), eb.cnt);
        check_bit({tag, "_ovf_b"}, ovf_b, eb.ovf);
      end
    end
  endtask

  task automatic finish_transfer(input logic [31:0] exp_cnt, input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_bit({tag, "_valid_after_ready"}, valid_a, 1'b0);
`ifdef FREQ_MEAS_CONTINUOUS_EN
    check_bit({tag, "_rearm_busy"}, busy_a, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
    check_bit({tag, "_idle_busy"}, busy_a, 1'b0);
    check({tag, "_idle_count"}, cnt_a, exp_cnt);
  endtask

  initial begin
    int seen;
    vecs[0] = '{2, 32'd25};
    vecs[1] = '{1, 32'd50};
    vecs[2] = '{5, 32'd10};
    vecs[3] = '{0, 32'd0};
    vecs[4] = '{50, 32'd1};
    vecs[5] = '{25, 32'd2};

    // reset state
    repeat (3) tick();
    check_bit("rst_busy", busy_a, 1'b0);
    check_bit("rst_valid", valid_a, 1'b0);
    check("rst_count", cnt_a, 32'd0);
    check_bit("rst_ovf", ovf_a, 1'b0);
    check("rst_count_b", 32'(cnt_b), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // table of signal periods
    for (int i = 0; i < 6; i++) begin
      h_a = vecs[i].half;
      repeat (6) tick();
      expect_result(vecs[i].exp_cnt);
      start = 1'b1;
      wait_result(102, $sformatf("vec%0d", i));
      finish_transfer(vecs[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // HOLD stalls for 20 cycles with start pulses ignored
    h_a = 2;
    repeat (6) tick();
    expect_result(32'd25);
    start = 1'b1;
    wait_result(102, "hold");
    for (int k = 0; k < 20; k++) begin
      if (k % 4 == 0) start = 1'b1;
      tick();
      start = 1'b0;
      check_bit("hold_valid", valid_a, 1'b1);
      check("hold_count", cnt_a, 32'd25);
      check_bit("hold_ovf", ovf_a, 1'b0);
      check_bit("hold_busy", busy_a, 1'b0);
    end
    finish_transfer(32'd25, "hold");

    // abort at gate cycle 50
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check_bit("abort50_pre_busy", busy_a, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_bit("abort50_busy", busy_a, 1'b0);
    seen = 0;
    repeat (120) begin
      tick();
      if (valid_a) seen = 1;
    end
    check("abort50_no_valid", 32'(seen), 32'd0);
    expect_result(32'd25);
    start = 1'b1;
    wait_result(102, "after_abort");
    finish_transfer(32'd25, "after_abort");

    // abort coinciding with the final gate cycle
    h_a = 5;
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_bit("abort_last_busy", busy_a, 1'b0);
    seen = 0;
    repeat (5) begin
      tick();
      if (valid_a) seen = 1;
    end
    check("abort_last_no_valid", 32'(seen), 32'd0);
    check("abort_last_count", cnt_a, 32'd25);

    // reset pulsed mid-gate
    h_a = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    #1;
    check_bit("midrst_busy", busy_a, 1'b0);
    check_bit("midrst_valid", valid_a, 1'b0);
    check("midrst_count", cnt_a, 32'd0);
    check_bit("midrst_ovf", ovf_a, 1'b0);
    check("midrst_count_b", 32'(cnt_b), 32'd0);
    check_bit("midrst_ovf_b", ovf_b, 1'b0);
    tick();
    reset = 1'b0;
    expect_result(32'd25);
    start = 1'b1;
    wait_result(102, "post_reset");
    finish_transfer(32'd25, "post_reset");

`ifdef FREQ_MEAS_CONTINUOUS_EN
    // back-to-back measurements of a constant-high signal
    h_a = 0;
    repeat (6) tick();
    expect_result(32'd0);
    start = 1'b1;
    wait_result(102, "cont1");
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_bit("cont1_rearm", busy_a, 1'b1);
    check_bit("cont1_valid_low", valid_a, 1'b0);
    expect_result(32'd0);
    wait_result(101, "cont2");
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_bit("cont2_rearm", busy_a, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_bit("cont_abort_idle", busy_a, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 1000000: gate window length in clock cycles, legal range 1 to 2^32-1.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the edge count result.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a measurement.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels an in-progress measurement.
REQ-007 The block SHALL have port sig_in, input, 1 bit: asynchronous signal under measurement.
REQ-008 The block SHALL have port result_ready, input, 1 bit: consumer accepts the result.
REQ-009 The block SHALL have port busy, output, 1 bit: high in ARM or GATE.
REQ-010 The block SHALL have port result_valid, output, 1 bit: high in HOLD.
REQ-011 The block SHALL have port result_count, output, CNT_W bits: rising edges of sig_in counted during the gate window.
REQ-012 The block SHALL have port overflow, output, 1 bit: the count saturated during the window.

Function
REQ-013 The block SHALL pass sig_in through a 2-flop synchronizer plus one delay flop; a rising edge is synchronized value 1 with delayed value 0.
REQ-014 The block SHALL implement an FSM with states IDLE, ARM, GATE and HOLD.
REQ-015 In IDLE, start=1 SHALL move the FSM to ARM; start SHALL be ignored in every other state.
REQ-016 ARM SHALL last exactly 1 cycle, clear the edge counter, gate timer and overflow, then enter GATE.
REQ-017 GATE SHALL last exactly GATE_CYCLES cycles, counting one per cycle in which an edge is detected, then enter HOLD.
REQ-018 result_count and overflow SHALL be registered on GATE exit, with result_valid high from the first HOLD cycle.
REQ-019 Start-to-result_valid latency SHALL be GATE_CYCLES+2 cycles.
REQ-020 The edge counter SHALL saturate at 2^CNT_W-1; an edge at saturation SHALL set overflow and leave the count unchanged.
REQ-021 In HOLD, result_valid, result_count and overflow SHALL stay stable until result_ready=1.
REQ-022 result_ready=1 in HOLD SHALL complete the transfer in that cycle and move the FSM to IDLE.
REQ-023 result_ready SHALL be ignored outside HOLD.
REQ-024 abort=1 in ARM or GATE SHALL move the FSM to IDLE next cycle with no result_valid; abort SHALL be ignored in IDLE and HOLD.
REQ-025 If abort and the final GATE cycle coincide, abort SHALL win.
REQ-026 result_count SHALL hold its last accepted value while in IDLE.

Reset
REQ-027 reset=1 SHALL immediately force the FSM to IDLE, busy=0, result_valid=0, result_count=0, overflow=0, and clear the synchronizer flops, gate timer and edge counter, including mid-GATE or mid-HOLD.
REQ-028 The first start SHALL be accepted on the first rising clock edge after reset deasserts.

Configuration
REQ-029 With macro FREQ_MEAS_CONTINUOUS_EN defined, result_ready=1 in HOLD SHALL move the FSM to ARM (back-to-back measurement) instead of IDLE, and only abort or reset SHALL return it to IDLE; abort SHALL then also be honored in HOLD.
REQ-030 Without FREQ_MEAS_CONTINUOUS_EN, the behaviour SHALL be exactly REQ-022 and REQ-024.

Structure
REQ-031 A shared package freq_meas_pkg SHALL hold the FSM state enum (IDLE, ARM, GATE, HOLD), the default GATE_CYCLES and the default CNT_W.
REQ-032 The synchronizer, edge detect and saturating counter SHALL be one sub-module, sig_edge_counter, with inputs clear and enable and outputs count and sat.

Verification
REQ-033 The bench SHALL cover: GATE_CYCLES=100, CNT_W=32, sig_in toggling every 2 clocks (period 4), start -> result_valid at cycle 102, result_count=25, overflow=0.
REQ-034 The bench SHALL cover: GATE_CYCLES=100, CNT_W=4, sig_in period 2 -> result_count=15, overflow=1.
REQ-035 The bench SHALL cover: abort at GATE cycle 50 -> busy=0 next cycle, result_valid never asserted, a following start measures normally.
REQ-036 The bench SHALL cover: result_ready held low 20 cycles in HOLD -> result_valid, result_count and overflow stable, start pulses ignored, IDLE one cycle after result_ready=1.
REQ-037 The bench SHALL cover: reset pulsed mid-GATE -> all outputs 0 immediately, FSM in IDLE.
REQ-038 The bench SHALL cover: with FREQ_MEAS_CONTINUOUS_EN and sig_in constant 1, two accepted results each with result_count=0, and a re-ARM the cycle after each result_ready.
